// File: rtl/perf_report_packetizer_if.sv
// Report word stream from the perf packetizer toward the NoC injection port
// or a debug sink: valid/ready handshake with an end-of-packet marker.
interface perf_report_packetizer_if;
    logic        rpt_valid;
    logic [31:0] rpt_data;
    logic        rpt_last;
    logic        rpt_ready;

    modport master (
        output rpt_valid,
        output rpt_data,
        output rpt_last,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_data,
        input  rpt_last,
        output rpt_ready
    );
endinterface

// File: rtl/perf_report_packetizer.sv
// Runs fixed-length perf-monitor measurement windows and streams a snapshot
// of the monitor's metrics as one multi-word report packet per window.
module perf_report_packetizer #(
    parameter int         NUM_CORES = 4,
    parameter logic [7:0] MAGIC     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_enable,
    input  logic [31:0]              cfg_interval,
    output logic                     start_measurement,
    output logic                     stop_measurement,
    output logic                     reset_counters,
    input  logic [31:0]              total_instructions,
    input  logic [31:0]              instructions_per_core [NUM_CORES],
    input  logic [31:0]              l1i_hit_rate,
    input  logic [31:0]              l1d_hit_rate,
    input  logic [31:0]              l2_hit_rate,
    input  logic [31:0]              avg_memory_latency,
    input  logic [31:0]              noc_average_latency,
    input  logic [31:0]              coherence_traffic_percentage,
    perf_report_packetizer_if.master rpt,
    output logic                     busy,
    output logic [15:0]              report_seq
);
    localparam int W     = NUM_CORES + 9;
    localparam int IDX_W = $clog2(W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_SNAPSHOT,
        S_SEND
    } state_t;

    typedef struct packed {
        logic [31:0]                 total;
        logic [NUM_CORES-1:0][31:0]  cores;
        logic [5:0][31:0]            rates;
    } snap_t;

    state_t           state_q, state_d;
    logic [31:0]      win_cnt_q, win_cnt_d;
    logic [31:0]      win_len_q, win_len_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      seq_q, seq_d;
    snap_t            snap_q, snap_d;
    snap_t            snap_in;
    logic [31:0]      interval_eff;
    logic [W-1:0][31:0] words;

    assign interval_eff = (cfg_interval == 32'd0) ? 32'd1 : cfg_interval;

    always_comb begin
        snap_in       = '0;
        snap_in.total = total_instructions;
        for (int i = 0; i < NUM_CORES; i++) begin
            snap_in.cores[i] = instructions_per_core[i];
        end
        snap_in.rates[0] = l1i_hit_rate;
        snap_in.rates[1] = l1d_hit_rate;
        snap_in.rates[2] = l2_hit_rate;
        snap_in.rates[3] = avg_memory_latency;
        snap_in.rates[4] = noc_average_latency;
        snap_in.rates[5] = coherence_traffic_percentage;
    end

    // Packet layout: header, total, per-core counts, rates/latencies, win_len.
    always_comb begin
        words    = '0;
        words[0] = {MAGIC, 8'(W - 1), seq_q};
        words[1] = snap_q.total;
        for (int i = 0; i < NUM_CORES; i++) begin
            words[2 + i] = snap_q.cores[i];
        end
        for (int i = 0; i < 6; i++) begin
            words[NUM_CORES + 2 + i] = snap_q.rates[i];
        end
        words[W - 1] = win_len_q;
    end

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        win_len_d = win_len_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        snap_d    = snap_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_enable) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                win_cnt_d = interval_eff;
                win_len_d = interval_eff;
                state_d   = S_MEASURE;
            end
            S_MEASURE: begin
                win_cnt_d = win_cnt_q - 32'd1;
                if (win_cnt_q == 32'd1) state_d = S_SNAPSHOT;
            end
            S_SNAPSHOT: begin
                snap_d  = snap_in;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (rpt.rpt_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        seq_d   = seq_q + 16'd1;
                        state_d = cfg_enable ? S_CLEAR : S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            win_cnt_q <= '0;
            win_len_q <= '0;
            idx_q     <= '0;
            seq_q     <= '0;
            snap_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            win_len_q <= win_len_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            snap_q    <= snap_d;
        end
    end

    // Outputs decode flops only; rpt_ready never reaches rpt_valid.
    assign reset_counters    = (state_q == S_CLEAR);
    assign start_measurement = (state_q == S_CLEAR);
    assign stop_measurement  = (state_q == S_MEASURE) && (win_cnt_q == 32'd1);
    assign rpt.rpt_valid     = (state_q == S_SEND);
    assign rpt.rpt_data      = (state_q == S_SEND) ? words[idx_q] : 32'd0;
    assign rpt.rpt_last      = (state_q == S_SEND) && (idx_q == LAST_IDX);
    assign busy              = (state_q != S_IDLE);
    assign report_seq        = seq_q;
endmodule

// File: tb/tb_perf_report_packetizer.sv
// Directed bench for perf_report_packetizer: a table of per-cycle ready/expected
// word rows for a stalled packet, plus hand-written multi-window and reset sequences.
module tb_perf_report_packetizer;
    localparam int NC = 4;
    localparam int W  = NC + 9;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [31:0] cfg_interval = 32'd0;
    logic        start_measurement, stop_measurement, reset_counters, busy;
    logic [15:0] report_seq;
    logic [31:0] total_instructions;
    logic [31:0] instructions_per_core [NC];
    logic [31:0] l1i_hit_rate, l1d_hit_rate, l2_hit_rate;
    logic [31:0] avg_memory_latency, noc_average_latency, coherence_traffic_percentage;

    perf_report_packetizer_if rpt();

    perf_report_packetizer #(.NUM_CORES(NC), .MAGIC(8'hA5)) dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .cfg_enable                   (cfg_enable),
        .cfg_interval                 (cfg_interval),
        .start_measurement            (start_measurement),
        .stop_measurement             (stop_measurement),
        .reset_counters               (reset_counters),
        .total_instructions           (total_instructions),
        .instructions_per_core        (instructions_per_core),
        .l1i_hit_rate                 (l1i_hit_rate),
        .l1d_hit_rate                 (l1d_hit_rate),
        .l2_hit_rate                  (l2_hit_rate),
        .avg_memory_latency           (avg_memory_latency),
        .noc_average_latency          (noc_average_latency),
        .coherence_traffic_percentage (coherence_traffic_percentage),
        .rpt                          (rpt),
        .busy                         (busy),
        .report_seq                   (report_seq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic        ready;
        logic [31:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] pkt0 [W];
    logic [31:0] pkt  [W];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_metrics(input logic [31:0] tot, input logic [31:0] c0, input logic [31:0] c1,
                               input logic [31:0] c2, input logic [31:0] c3, input logic [31:0] r0,
                               input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3,
                               input logic [31:0] r4, input logic [31:0] r5);
        total_instructions           = tot;
        instructions_per_core[0]     = c0;
        instructions_per_core[1]     = c1;
        instructions_per_core[2]     = c2;
        instructions_per_core[3]     = c3;
        l1i_hit_rate                 = r0;
        l1d_hit_rate                 = r1;
        l2_hit_rate                  = r2;
        avg_memory_latency           = r3;
        noc_average_latency          = r4;
        coherence_traffic_percentage = r5;
    endtask

    // Entered at the negedge of the first SEND cycle; leaves at the negedge after final accept.
    task automatic recv_packet(input string tag, input logic [31:0] exp [W]);
        rpt.rpt_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), {31'd0, rpt.rpt_valid}, 32'd1);
            chk($sformatf("%s_word%0d", tag, i), rpt.rpt_data, exp[i]);
            chk($sformatf("%s_last%0d", tag, i), {31'd0, rpt.rpt_last}, (i == W - 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && start_measurement && stop_measurement)
            chk("start_stop_exclusive", 32'd1, 32'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rpt.rpt_ready = 1'b1;
        set_metrics(32'h100, 1, 2, 3, 4, 90, 80, 70, 5, 6, 25);

        pkt0 = '{32'hA50C0000, 32'h100, 32'd1, 32'd2, 32'd3, 32'd4,
                 32'd90, 32'd80, 32'd70, 32'd5, 32'd6, 32'd25, 32'd10};
        begin
            int  widx;
            int  c;
            bit  rdy_pat [4];
            rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
            widx = 0;
            c = 0;
            while (widx < W) begin
                vec_t v;
                v.ready    = rdy_pat[c % 4];
                v.exp_data = pkt0[widx];
                v.exp_last = (widx == W - 1);
                tbl.push_back(v);
                if (v.ready) widx++;
                c++;
            end
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, rpt.rpt_valid}, 32'd0);
        chk("rst_data", rpt.rpt_data, 32'd0);
        chk("rst_last", {31'd0, rpt.rpt_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_seq", {16'd0, report_seq}, 32'd0);
        chk("rst_pulses", {29'd0, start_measurement, stop_measurement, reset_counters}, 32'd0);

        // Window 0: interval 10, stalled sink
        cfg_enable   = 1'b1;
        cfg_interval = 32'd10;
        reset_n      = 1'b1;
        @(negedge clk);
        chk("w0_clear_pulses", {30'd0, reset_counters, start_measurement}, 32'd3);
        chk("w0_clear_busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("w0_stop_c%0d", i), {31'd0, stop_measurement}, (i == 10) ? 32'd1 : 32'd0);
            chk($sformatf("w0_start_c%0d", i), {31'd0, start_measurement}, 32'd0);
        end
        @(negedge clk);
        chk("w0_snapshot_valid", {31'd0, rpt.rpt_valid}, 32'd0);
        @(negedge clk);
        set_metrics(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cfg_interval = 32'd0;
        for (int i = 0; i < tbl.size(); i++) begin
            rpt.rpt_ready = tbl[i].ready;
            chk($sformatf("tbl%0d_valid", i), {31'd0, rpt.rpt_valid}, 32'd1);
            chk($sformatf("tbl%0d_data", i), rpt.rpt_data, tbl[i].exp_data);
            chk($sformatf("tbl%0d_last", i), {31'd0, rpt.rpt_last}, {31'd0, tbl[i].exp_last});
            @(negedge clk);
        end
        rpt.rpt_ready = 1'b1;

        // Windows 1 and 2: interval 0 behaves as 1, back-to-back
        for (int w = 1; w <= 2; w++) begin
            chk($sformatf("w%0d_clear_start", w), {31'd0, start_measurement}, 32'd1);
            chk($sformatf("w%0d_clear_rstcnt", w), {31'd0, reset_counters}, 32'd1);
            chk($sformatf("w%0d_clear_valid", w), {31'd0, rpt.rpt_valid}, 32'd0);
            chk($sformatf("w%0d_seq", w), {16'd0, report_seq}, w);
            @(negedge clk);
            chk($sformatf("w%0d_stop", w), {31'd0, stop_measurement}, 32'd1);
            @(negedge clk);
            chk($sformatf("w%0d_snap_valid", w), {31'd0, rpt.rpt_valid}, 32'd0);
            @(negedge clk);
            pkt = '{default: 32'd0};
            pkt[0]     = 32'hA50C0000 | w;
            pkt[W - 1] = 32'd1;
            recv_packet($sformatf("w%0d", w), pkt);
        end

        // Window 3: async reset while word 5 is on the bus
        chk("w3_clear_start", {31'd0, start_measurement}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) chk("w3_hdr", rpt.rpt_data, 32'hA50C0003);
            @(negedge clk);
        end
        chk("w3_word5_valid", {31'd0, rpt.rpt_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, rpt.rpt_valid}, 32'd0);
        chk("rst_mid_data", rpt.rpt_data, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_seq", {16'd0, report_seq}, 32'd0);
        cfg_interval = 32'd4;
        set_metrics(32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fresh window after reset; cfg_enable dropped mid-MEASURE
        @(negedge clk);
        chk("w4_clear_start", {31'd0, start_measurement}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 2) cfg_enable = 1'b0;
            chk($sformatf("w4_stop_c%0d", i), {31'd0, stop_measurement}, (i == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("w4_snap_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        pkt = '{default: 32'd0};
        pkt[0]     = 32'hA50C0000;
        pkt[1]     = 32'h1234;
        pkt[W - 1] = 32'd4;
        recv_packet("w4", pkt);
        chk("w4_idle_busy", {31'd0, busy}, 32'd0);
        chk("w4_idle_valid", {31'd0, rpt.rpt_valid}, 32'd0);
        chk("w4_idle_seq", {16'd0, report_seq}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("w4_idle_start%0d", i), {31'd0, start_measurement}, 32'd0);
            chk($sformatf("w4_idle_busy%0d", i), {31'd0, busy}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/perf_report_packetizer.md
Name: perf_report_packetizer

Overview:
- Drives the performance monitor's control interface (start_measurement, stop_measurement, reset_counters) to run fixed-length measurement windows.
- At the end of each window, snapshots the monitor's metric outputs and streams them as a multi-word report packet over a valid/ready interface toward the NoC injection port or a debug sink.
- Runs once or back-to-back windows under cfg_enable.

Parameters:
NUM_CORES, 4, number of per-core instruction counts in the snapshot and packet
MAGIC, 8'hA5, header tag in word0[31:24]

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
cfg_enable  in  1  level; run windows while high
cfg_interval  in  32  window length in cycles; sampled in CLEAR; 0 treated as 1
start_measurement  out  1  one-cycle pulse to monitor
stop_measurement  out  1  one-cycle pulse to monitor
reset_counters  out  1  one-cycle pulse to monitor
total_instructions  in  32  monitor metric
instructions_per_core  in  32 x NUM_CORES  monitor metric, unpacked array
l1i_hit_rate, l1d_hit_rate, l2_hit_rate  in  32 each  monitor metrics
avg_memory_latency, noc_average_latency, coherence_traffic_percentage  in  32 each  monitor metrics
rpt_valid  out  1  report word valid
rpt_data  out  32  report word
rpt_last  out  1  final word of packet
rpt_ready  in  1  sink accepts word
busy  out  1  high in any state other than IDLE
report_seq  out  16  sequence number of the next packet

Behaviour:
- Reset: all outputs 0; state IDLE; report_seq 0; shadow registers 0. Async reset mid-packet drops the packet (rpt_valid 0 immediately); no partial resend.
- FSM states and transitions:
  - IDLE: if cfg_enable, go to CLEAR.
  - CLEAR, 1 cycle:
    - Assert reset_counters and start_measurement together.
    - Load win_cnt = max(cfg_interval,1); latch the same value into win_len.
    - Go to MEASURE.
  - MEASURE:
    - Decrement win_cnt each cycle.
    - Assert stop_measurement in the cycle win_cnt==1, then go to SNAPSHOT.
    - The monitor therefore counts events in exactly win_len cycles (the cycles after CLEAR, through the stop cycle).
  - SNAPSHOT, 1 cycle:
    - Monitor counters are frozen.
    - Capture all metric inputs into shadow registers.
    - Set word index 0; go to SEND.
  - SEND:
    - rpt_valid=1 and rpt_data = word[idx].
    - On rpt_valid && rpt_ready: idx++.
    - On the last word: report_seq++ (wraps FFFF->0), then go to CLEAR if cfg_enable, else IDLE.
- Control pulses are decoded from state/counter flops only, so they are glitch-free. start and stop never coincide.
- Packet word order (W = NUM_CORES+9 words; 13 at default):
  - word0 header = {MAGIC, 8'(W-1), report_seq}
  - word1 total_instructions
  - words 2..NUM_CORES+1: instructions_per_core[0..NUM_CORES-1]
  - then l1i_hit_rate, l1d_hit_rate, l2_hit_rate, avg_memory_latency, noc_average_latency, coherence_traffic_percentage
  - final word: win_len
- rpt_last=1 only with the final word.
- Handshake:
  - rpt_data and rpt_last hold stable while rpt_valid && !rpt_ready.
  - rpt_valid never drops before its word is accepted.
  - No combinational path from rpt_ready to rpt_valid.
  - One word per cycle under constant ready.
- Snapshot isolation: metric input changes after SNAPSHOT do not affect the packet in flight.
- cfg_enable is sampled only in IDLE and at final-word acceptance. Deassertion mid-window completes the window and its packet.
- cfg_interval changes mid-window take effect at the next CLEAR.
- The monitor is not measuring during SEND; back-to-back windows have a gap of W + 2 cycles minimum (SNAPSHOT, SEND, CLEAR) under full ready.
- Latency: with constant ready, rpt_valid rises 2 cycles after the stop_measurement cycle. The final word is accepted W-1 cycles later.

Test Plan:
1. Reset, cfg_enable=1, cfg_interval=10 -> reset_counters+start pulse at cycle 1, stop pulse exactly 10 cycles later; header = 0xA50C0000; final word = 10; rpt_last only on word 12.
2. Metric inputs held at distinct values (total=0x100, per-core 1..4, rates 90/80/70, latencies 5/6, coherence 25); change all inputs to 0 during SEND -> packet carries the original values in specified order.
3. rpt_ready toggling 1,0,0,1 pattern during SEND -> each word held stable while stalled; 13 unique words transferred, none duplicated or skipped.
4. cfg_enable high for 3 windows, interval=0 -> each window 1 cycle; headers carry seq 0,1,2; CLEAR follows the final word acceptance by 1 cycle.
5. Deassert cfg_enable mid-MEASURE -> window and packet complete, FSM returns to IDLE, busy=0, report_seq=1.
6. Assert reset_n low in the middle of SEND (word 5) -> rpt_valid/outputs 0 immediately, report_seq=0; after release with cfg_enable=1, a fresh packet starts at header seq 0.
